// File: rtl/hpdcache_mem_read_responder.sv
// HPDcache memory read responder: queues refill read requests and
// answers each with a latency-delayed burst of address-derived beats.
module hpdcache_mem_read_responder #(
  parameter int PA_WIDTH       = 49,
  parameter int MEM_ID_WIDTH   = 4,
  parameter int MEM_DATA_WIDTH = 512,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int LAT_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [LAT_WIDTH-1:0]      cfg_latency_i,
  input  logic [PA_WIDTH-1:0]       cfg_err_base_i,
  output logic                      mem_req_read_ready_o,
  input  logic                      mem_req_read_valid_i,
  input  logic [PA_WIDTH-1:0]       mem_req_read_addr_i,
  input  logic [7:0]                mem_req_read_len_i,
  input  logic [MEM_ID_WIDTH-1:0]   mem_req_read_id_i,
  input  logic                      mem_resp_read_ready_i,
  output logic                      mem_resp_read_valid_o,
  output logic [1:0]                mem_resp_read_error_o,
  output logic [MEM_ID_WIDTH-1:0]   mem_resp_read_id_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_resp_read_data_o,
  output logic                      mem_resp_read_last_o,
  output logic                      busy_o
);

  localparam int BYTES = MEM_DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int LANES = MEM_DATA_WIDTH / 64;
  localparam int PW    = $clog2(REQ_FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  logic [PA_WIDTH-1:0]     f_addr_q [REQ_FIFO_DEPTH];
  logic [7:0]              f_len_q  [REQ_FIFO_DEPTH];
  logic [MEM_ID_WIDTH-1:0] f_id_q   [REQ_FIFO_DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop;

  logic [1:0]              state_q, state_d;
  logic [PA_WIDTH-1:0]     base_q, base_d;
  logic [7:0]              beat_q, beat_d;
  logic [7:0]              len_q, len_d;
  logic [MEM_ID_WIDTH-1:0] id_q, id_d;
  logic                    err_q, err_d;
  logic [LAT_WIDTH-1:0]    lcnt_q, lcnt_d;

  logic [PA_WIDTH-1:0] beat_addr;
  logic                in_burst;

  assign mem_req_read_ready_o =
    (cnt_q != (PW+1)'(REQ_FIFO_DEPTH));
  assign push = mem_req_read_valid_i
              & mem_req_read_ready_o;
  assign pop  = (state_q == IDLE)
              & (cnt_q != '0);
  assign busy_o = (cnt_q != '0)
                | (state_q != IDLE);

  // FIFO pointer and occupancy update
  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push)
                   - (PW+1)'(pop);
  end

  // FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      f_addr_q[wptr_q] <= mem_req_read_addr_i;
      f_len_q[wptr_q]  <= mem_req_read_len_i;
      f_id_q[wptr_q]   <= mem_req_read_id_i;
    end
  end

  // Burst sequencer: pop, wait out the latency, stream the beats
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    len_d   = len_q;
    id_d    = id_q;
    err_d   = err_q;
    lcnt_d  = lcnt_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          base_d = f_addr_q[rptr_q]
                 & ~PA_WIDTH'(BYTES - 1);
          beat_d = '0;
          len_d  = f_len_q[rptr_q];
          id_d   = f_id_q[rptr_q];
          err_d  = f_addr_q[rptr_q]
                   >= cfg_err_base_i;
          lcnt_d = cfg_latency_i;
          state_d = (cfg_latency_i != '0)
                  ? WAIT : BURST;
        end
      end
      WAIT: begin
        lcnt_d = lcnt_q - LAT_WIDTH'(1);
        if (lcnt_q == LAT_WIDTH'(1))
          state_d = BURST;
      end
      BURST: begin
        if (mem_resp_read_ready_i) begin
          if (beat_q == len_q)
            state_d = IDLE;
          else
            beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response beat generation from the working registers
  always_comb begin
    in_burst  = (state_q == BURST);
    beat_addr = base_q
              + (PA_WIDTH'(beat_q) << OFS);
    mem_resp_read_valid_o = in_burst;
    mem_resp_read_last_o  = in_burst
                          & (beat_q == len_q);
    mem_resp_read_id_o    = in_burst ? id_q : '0;
    mem_resp_read_error_o = (in_burst & err_q)
                          ? 2'b10 : 2'b00;
    mem_resp_read_data_o  = '0;
    if (in_burst && !err_q) begin
      for (int k = 0; k < LANES; k++) begin
        mem_resp_read_data_o[k*64 +: 64] =
          64'(beat_addr + PA_WIDTH'(8 * k));
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      lcnt_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      id_q    <= id_d;
      err_q   <= err_d;
      lcnt_q  <= lcnt_d;
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// Directed self-checking bench for the HPDcache memory
// read responder.
module tb_hpdcache_mem_read_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   cfg_lat;
  logic [48:0]  cfg_err;
  logic         req_rdy;
  logic         req_vld;
  logic [48:0]  req_addr;
  logic [7:0]   req_len;
  logic [3:0]   req_id;
  logic         rsp_rdy;
  logic         rsp_vld;
  logic [1:0]   rsp_err;
  logic [3:0]   rsp_id;
  logic [511:0] rsp_data;
  logic         rsp_last;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hpdcache_mem_read_responder dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .cfg_latency_i         (cfg_lat),
    .cfg_err_base_i        (cfg_err),
    .mem_req_read_ready_o  (req_rdy),
    .mem_req_read_valid_i  (req_vld),
    .mem_req_read_addr_i   (req_addr),
    .mem_req_read_len_i    (req_len),
    .mem_req_read_id_i     (req_id),
    .mem_resp_read_ready_i (rsp_rdy),
    .mem_resp_read_valid_o (rsp_vld),
    .mem_resp_read_error_o (rsp_err),
    .mem_resp_read_id_o    (rsp_id),
    .mem_resp_read_data_o  (rsp_data),
    .mem_resp_read_last_o  (rsp_last),
    .busy_o                (busy)
  );

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_data(
      input logic [48:0] a, input bit err);
    logic [511:0] d;
    logic [48:0]  t;
    d = '0;
    if (!err) begin
      for (int k = 0; k < 8; k++) begin
        t = a + 49'(8 * k);
        d[k*64 +: 64] = 64'(t);
      end
    end
    return d;
  endfunction

  task automatic send(input logic [48:0] a,
                      input logic [7:0] l,
                      input logic [3:0] id);
    int t = 0;
    req_vld  = 1'b1;
    req_addr = a;
    req_len  = l;
    req_id   = id;
    while (!req_rdy && t < 100) begin
      tick();
      t++;
    end
    chk("req_timeout", 512'(t >= 100), '0);
    tick();
    req_vld = 1'b0;
  endtask

  task automatic recv(input logic [3:0] id,
                      input logic [48:0] base,
                      input logic [7:0] len,
                      input bit err,
                      input int bp);
    int e = 0;
    int cyc = 0;
    int to = 0;
    bit stalled = 0;
    logic [511:0] hold = '0;
    logic [3:0] pat = 4'b1001;
    logic [48:0] ba;
    while (!rsp_vld && to < 100) begin
      tick();
      to++;
    end
    chk("rsp_timeout", 512'(to >= 100), '0);
    while (e <= int'(len) && cyc < 200) begin
      rsp_rdy = (bp == 0) ? 1'b1
              : pat[3 - (cyc % 4)];
      chk("vld_in_burst", 512'(rsp_vld), 512'(1));
      if (rsp_vld) begin
        if (stalled)
          chk("stall_hold", rsp_data, hold);
        ba = base + 49'(e) * 49'd64;
        chk("rsp_id", 512'(rsp_id), 512'(id));
        chk("rsp_last", 512'(rsp_last),
            512'(e == int'(len)));
        chk("rsp_err", 512'(rsp_err),
            err ? 512'(2) : 512'(0));
        chk("rsp_data", rsp_data, exp_data(ba, err));
        hold = rsp_data;
        stalled = !rsp_rdy;
        if (rsp_rdy) e++;
      end
      tick();
      cyc++;
    end
    chk("beats", 512'(e), 512'(int'(len) + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst      = 1'b1;
    cfg_lat  = 8'd0;
    cfg_err  = '1;
    req_vld  = 1'b0;
    req_addr = '0;
    req_len  = '0;
    req_id   = '0;
    rsp_rdy  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 512'(rsp_vld), '0);
    chk("rst_last", 512'(rsp_last), '0);
    chk("rst_err", 512'(rsp_err), '0);
    chk("rst_id", 512'(rsp_id), '0);
    chk("rst_data", rsp_data, '0);
    chk("rst_busy", 512'(busy), '0);
    chk("rst_ready", 512'(req_rdy), 512'(1));

    // single beat, latency 0: valid at T+2
    send(49'h1000, 8'd0, 4'd3);
    chk("t1_vld_t1", 512'(rsp_vld), '0);
    chk("t1_busy", 512'(busy), 512'(1));
    tick();
    chk("t1_vld_t2", 512'(rsp_vld), 512'(1));
    chk("t1_lane0", 512'(rsp_data[63:0]),
        512'(64'h1000));
    chk("t1_lane7", 512'(rsp_data[511:448]),
        512'(64'h1038));
    recv(4'd3, 49'h1000, 8'd0, 0, 0);

    // burst with latency 5: first beat at T+7
    cfg_lat = 8'd5;
    send(49'h2040, 8'd3, 4'd1);
    repeat (5) tick();
    chk("t2_vld_t6", 512'(rsp_vld), '0);
    tick();
    chk("t2_vld_t7", 512'(rsp_vld), 512'(1));
    recv(4'd1, 49'h2040, 8'd3, 0, 0);
    chk("t2_idle_gap", 512'(rsp_vld), '0);

    // backpressure pattern 1,0,0,1
    cfg_lat = 8'd0;
    send(49'h3000, 8'd3, 4'd2);
    recv(4'd2, 49'h3000, 8'd3, 0, 1);
    rsp_rdy = 1'b1;

    // address wrap at top of the space
    send(49'h1FFFF_FFFF_FFC0, 8'd1, 4'd4);
    recv(4'd4, 49'h1FFFF_FFFF_FFC0, 8'd1, 0, 0);

    // FIFO full with response stalled
    rsp_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_vld  = 1'b1;
      req_id   = 4'(i);
      req_addr = 49'h4000 + 49'(64 * i);
      req_len  = 8'd0;
      if (!req_rdy) break;
      tick();
      acc++;
    end
    chk("full_accepted", 512'(acc), 512'(5));
    chk("full_ready", 512'(req_rdy), '0);
    chk("full_busy", 512'(busy), 512'(1));
    fork
      begin
        int t = 0;
        while (!req_rdy && t < 50) begin
          tick();
          t++;
        end
        chk("full_push_to", 512'(t >= 50), '0);
        tick();
        req_vld = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++)
          recv(4'(i), 49'h4000 + 49'(64 * i),
               8'd0, 0, 0);
      end
    join
    rsp_rdy = 1'b1;

    // error region, then a normal request
    cfg_err = 49'h8000_0000;
    send(49'h8000_0000, 8'd1, 4'd6);
    recv(4'd6, 49'h8000_0000, 8'd1, 1, 0);
    send(49'h100, 8'd0, 4'd7);
    recv(4'd7, 49'h100, 8'd0, 0, 0);

    // reset during beat 2 of an 8-beat burst
    send(49'h5000, 8'd7, 4'd9);
    acc = 0;
    while (!rsp_vld && acc < 100) begin
      tick();
      acc++;
    end
    chk("rb_vld_to", 512'(acc >= 100), '0);
    chk("rb_beat0", 512'(rsp_data[63:0]),
        512'(64'h5000));
    tick();
    tick();
    chk("rb_beat2", 512'(rsp_data[63:0]),
        512'(64'h5080));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_vld", 512'(rsp_vld), '0);
    chk("rb_busy", 512'(busy), '0);
    chk("rb_ready", 512'(req_rdy), 512'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rb_quiet", 512'(rsp_vld), '0);
    end
    send(49'h6000, 8'd1, 4'd10);
    recv(4'd10, 49'h6000, 8'd1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hpdcache_mem_read_responder.md
Name: hpdcache_mem_read_responder

Overview:
- Memory-side responder for the HPDcache refill read interface: it is the other end of the cache's memory read request channel.
- Accepts read requests into a small request FIFO. After a programmable latency, returns a burst of response beats carrying address-derived data, an ID and a last flag.
- Used in the verification environment as the synthesizable memory slave behind the cache under test; also serves as a reference for backpressure and error handling.

Parameters:
- PA_WIDTH, 49, physical address width.
- MEM_ID_WIDTH, 4, request/response ID width.
- MEM_DATA_WIDTH, 512, beat data width in bits; multiple of 64.
- REQ_FIFO_DEPTH, 4, request FIFO entries; power of 2, ≥2.
- LAT_WIDTH, 8, width of the latency configuration.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_latency_i  in  LAT_WIDTH  wait cycles inserted before the first beat of each request
- cfg_err_base_i  in  PA_WIDTH  addresses ≥ this value return an error
- mem_req_read_ready_o  out  1  request accepted when valid & ready
- mem_req_read_valid_i  in  1  request valid
- mem_req_read_addr_i  in  PA_WIDTH  request byte address
- mem_req_read_len_i  in  8  number of beats minus 1
- mem_req_read_id_i  in  MEM_ID_WIDTH  transaction ID
- mem_resp_read_ready_i  in  1  response backpressure
- mem_resp_read_valid_o  out  1  response beat valid
- mem_resp_read_error_o  out  2  2'b00 OK, 2'b10 SLVERR
- mem_resp_read_id_o  out  MEM_ID_WIDTH  ID echoed from the request
- mem_resp_read_data_o  out  MEM_DATA_WIDTH  beat data
- mem_resp_read_last_o  out  1  final beat of the burst
- busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO emptied; FSM goes to IDLE.
  - mem_resp_read_valid_o=0, last=0, error=0, id=0, data=0, busy_o=0.
  - mem_req_read_ready_o=1 from the first cycle after reset.
  - Reset mid-burst drops all in-flight and queued requests; no further beats are emitted.
- Request side:
  - ready_o = !fifo_full.
  - On a request handshake, {addr, len, id} is pushed.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- The FIFO head is visible the cycle after the push (registered).
- FSM states are IDLE, WAIT and BURST:
  - IDLE: if the FIFO is non-empty, pop the head into working registers (base = addr aligned down to MEM_DATA_WIDTH/8, beat=0, len, id). Latch err = (addr ≥ cfg_err_base_i) and cnt = cfg_latency_i. Go to WAIT if cfg_latency_i≠0, else BURST.
  - WAIT: cnt decrements each cycle; when cnt==1, go to BURST. This gives exactly cfg_latency_i cycles in WAIT.
  - BURST: valid_o=1 and all outputs are driven from the working registers.
    - Outputs are held stable while !ready_i.
    - On a handshake with beat<len: beat++.
    - On a handshake with beat==len (last_o=1): go to IDLE. There is one idle cycle between bursts.
- Latency: with an empty FIFO and IDLE FSM, a request handshaking at cycle T gives first valid_o at T+2+cfg_latency_i.
- Beat data:
  - beat_addr = base + beat*(MEM_DATA_WIDTH/8), computed modulo 2^PA_WIDTH (wraps at top of address space).
  - 64-bit lane k = zero-extended (beat_addr + 8*k).
- Error handling:
  - If err is set, every beat of the burst has error=2'b10 and data=0.
  - Beat count still equals len+1 and last is still asserted.
- Ordering: responses are returned strictly in request order; the ID is echoed and not reordered.
- cfg_* inputs are sampled only at pop; changes during a burst do not affect it.
- busy_o is combinational from FIFO-empty and FSM state.

Test Plan:
- Single request (addr=0x1000, len=0, id=3, latency=0, ready_i=1):
  - valid at T+2 with last=1, id=3, error=0, lane0=0x1000, lane7=0x1038.
- Burst, latency=5 (addr=0x2040, len=3, MEM_DATA_WIDTH=512):
  - 4 beats starting at T+7.
  - Beat bases 0x2040, 0x2080, 0x20C0, 0x2100; last only on the 4th.
- Backpressure:
  - Toggle ready_i with pattern 1,0,0,1 during a burst.
  - Outputs stay stable while stalled; no beat is lost or duplicated.
- FIFO full:
  - Hold ready_i=0 and issue 6 back-to-back requests (len=0, ids 0–5).
  - ready_o drops after 5 accepted (4 in FIFO + 1 in FSM).
  - Releasing ready_i returns ids 0–5 in order.
- Error (cfg_err_base=0x8000_0000, addr=0x8000_0000, len=1):
  - 2 beats with error=2'b10, data=0, last on the second.
  - A following request to addr=0x100 returns error=0.
- Reset mid-burst (rst_i asserted during beat 2 of len=7):
  - Next cycle valid=0, busy_o=0, ready_o=1.
  - A new request completes normally with correct data.
